i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (responder) that pairs with the in-house `master` block on the shared scl/sda bus.
- Oversamples scl/sda on the system clock and detects START, repeated START and STOP.
- Decodes the 7-bit address and R/W bit, ACKs on address match, then receives write bytes or transmits read bytes.
- Presents a simple byte-wide handshake to local logic.

Parameters:
- SLAVE_ADDR, 7'h55, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer flop depth on scl and sda (minimum 2).

Ports:
- clock  input  1  system clock; must be at least 8x the SCL frequency.
- reset  input  1  synchronous, active-high reset.
- scl  input  1  I2C clock from the master; this block never stretches it.
- sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
- tx_data  input  8  byte to return on a read; sampled when tx_req is asserted.
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_req  output  1  one-cycle pulse requesting the next read byte.
- addr_match  output  1  one-cycle pulse on address match, after the R/W bit is sampled.
- rw  output  1  R/W bit of the current transfer (1 = read).
- busy  output  1  high from START until STOP or return to IDLE.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, tx_req=0, addr_match=0, rw=0, busy=0.
  - sda released (z); state=IDLE; bit counter=0.
- Input path:
  - scl and sda each pass through SYNC_STAGES flops.
  - Edge detection compares the last two synchronized samples.
  - Input-to-decision latency is SYNC_STAGES+1 clocks.
- Bus events:
  - scl_rise / scl_fall: synchronized scl edges.
  - START: sda falls while scl=1.
  - STOP: sda rises while scl=1.
  - START and STOP take priority over any state, including mid-byte.
- Bit timing:
  - Data is sampled on scl_rise.
  - The slave changes its sda drive only on scl_fall, one clock after the edge is detected.
- FSM states:
  - IDLE: wait for START; busy=0.
  - ADDR: shift 8 bits MSB-first on scl_rise. After the 8th bit:
    - match -> latch rw, pulse addr_match, go to ADDR_ACK;
    - mismatch -> go to WAIT_STOP with sda released (NACK).
  - ADDR_ACK: drive sda=0 from the scl_fall after bit 8 until the next scl_fall.
    - rw=0 -> RX_DATA.
    - rw=1 -> pulse tx_req at entry, latch tx_data one clock later, then TX_DATA.
  - RX_DATA: shift 8 bits. After the 8th, update rx_data, pulse rx_valid, go to RX_ACK.
  - RX_ACK: drive sda=0 for the 9th bit, then return to RX_DATA.
  - TX_DATA: drive MSB-first on each scl_fall (a 0 bit pulls low, a 1 bit releases). After 8 bits, release sda and go to TX_ACK.
  - TX_ACK: sample the master's sda on the 9th scl_rise.
    - 0 (ACK) -> pulse tx_req, reload, go to TX_DATA.
    - 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: sda released; ignore bits until STOP (-> IDLE) or START (-> ADDR).
- Boundaries:
  - Repeated START in any state: bit counter cleared, sda released, go to ADDR.
  - STOP in any state: sda released, go to IDLE, busy=0.
  - STOP in the middle of an RX byte: the partial byte is discarded and rx_valid does not pulse.
  - A General-call address (7'h00) is not recognised; it NACKs unless SLAVE_ADDR=0.
  - Reset asserted mid-transfer: all outputs return to reset values on the next clock edge and sda is released.
  - rx_valid, tx_req and addr_match are never high for more than one clock.

Optional Feature:
- I2C_GLITCH_FILTER_EN defined:
  - A 3-sample majority filter follows the synchronizer on both scl and sda.
  - Pulses of 1 clock or less are suppressed.
  - Input latency grows by 2 clocks.
- Not defined: the synchronizer output feeds edge detection directly.

Decomposition:
- Package i2c_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP);
  - localparams ACK=1'b0, NACK=1'b1, BITS_PER_BYTE=8.
- Sub-module i2c_line_sync: synchronizer, optional majority filter, rise/fall outputs. Instantiated once for scl and once for sda.

Test Plan:
- Write: START, addr 0x55+W, data 0xA5, STOP -> sda=0 during ACK on 9th clock; rx_data=0xA5 with one rx_valid pulse; busy falls after STOP.
- Address mismatch: START, 0x2A+W, data 0x12 -> sda stays z throughout; no addr_match or rx_valid; state returns to IDLE on STOP.
- Read: START, 0x55+R, tx_data=0x3C, master ACK, tx_data=0xC3, master NACK, STOP -> bus shows 0x3C then 0xC3; exactly 2 tx_req pulses; sda released after the NACK.
- Repeated START after 4 data bits, then 0x55+W, 0x0F -> partial byte discarded; rx_data=0x0F; single rx_valid.
- Reset asserted during the ACK low phase -> sda=z on the next clock; all outputs 0; the next full write of 0x77 succeeds.
- Glitch (I2C_GLITCH_FILTER_EN only): 1-clock sda low pulse while scl high in IDLE -> no START detected; busy stays 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus-level bit values.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_DATA,
        TX_ACK,
        WAIT_STOP
    } state_e;

    localparam logic ACK           = 1'b0;
    localparam logic NACK          = 1'b1;
    localparam int   BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_slave_if.sv
// Byte-wide handshake between the I2C target and local logic.
interface i2c_slave_if;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       addr_match;
    logic       rw;
    logic       busy;

    modport slave  (input tx_data, output rx_data, rx_valid, tx_req, addr_match, rw, busy);
    modport master (output tx_data, input rx_data, rx_valid, tx_req, addr_match, rw, busy);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer plus edge detect for one bus line; I2C_GLITCH_FILTER_EN inserts a
// 3-sample majority filter that suppresses single-clock pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   line;

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] filt_q, filt_d;

    always_comb filt_d = {filt_q[1:0], sync_q[SYNC_STAGES-1]};

    assign line = (filt_q[0] & filt_q[1]) | (filt_q[1] & filt_q[2]) | (filt_q[0] & filt_q[2]);

    always_ff @(posedge clock) begin
        if (reset) filt_q <= '1;
        else       filt_q <= filt_d;
    end
`else
    assign line = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = line;
    end

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = line;
    assign rise  = line & ~prev_q;
    assign fall  = ~line & prev_q;
endmodule

// File: rtl/i2c_slave.sv
// I2C target: decodes address/RW, ACKs on match, receives or transmits bytes.
// Optional input glitch filter: define I2C_GLITCH_FILTER_EN.
//   state     | meaning
//   IDLE      | bus free, waiting for START
//   ADDR      | shifting in address + R/W
//   ADDR_ACK  | driving address ACK; rw=1 preloads the first TX byte
//   RX_DATA   | shifting in a write byte
//   RX_ACK    | driving ACK for a received byte
//   TX_DATA   | driving a read byte MSB-first
//   TX_ACK    | sampling master ACK/NACK
//   WAIT_STOP | not addressed or NACKed; ignore until START/STOP
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          scl,
    inout  wire           sda,
    i2c_slave_if.slave    host
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clock (clock), .reset (reset), .din (scl),
        .level (scl_lvl), .rise (scl_rise), .fall (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clock (clock), .reset (reset), .din (sda),
        .level (sda_lvl), .rise (sda_rise), .fall (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addr_match_q, addr_match_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic [7:0] shift_in;

    assign shift_in = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        addr_match_d = 1'b0;
        rw_d         = rw_q;
        busy_d       = busy_q;

        // The byte requested last cycle is captured now, well before the next scl_fall.
        if (tx_req_q) shift_d = host.tx_data;

        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: busy_d = 1'b0;
                ADDR: if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(BITS_PER_BYTE - 1)) begin
                        bit_cnt_d = '0;
                        if (shift_q[6:0] == SLAVE_ADDR) begin
                            rw_d         = sda_lvl;
                            addr_match_d = 1'b1;
                            tx_req_d     = sda_lvl;
                            state_d      = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (rw_q) begin
                        // The ACK-ending fall also launches the first read bit.
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = 4'd1;
                        state_d   = TX_DATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = RX_DATA;
                    end
                end
                RX_DATA: if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(BITS_PER_BYTE - 1)) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = RX_ACK;
                    end
                end
                RX_ACK: if (scl_fall) begin
                    sda_oe_d = ~sda_oe_q;
                    if (sda_oe_q) state_d = RX_DATA;
                end
                TX_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 4'(BITS_PER_BYTE)) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = TX_ACK;
                    end else begin
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                TX_ACK: if (scl_rise) begin
                    if (sda_lvl == NACK) begin
                        state_d = WAIT_STOP;
                    end else begin
                        tx_req_d  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = TX_DATA;
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default:   state_d  = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            tx_req_q     <= tx_req_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
        end
    end

    assign sda             = sda_oe_q ? 1'b0 : 1'bz;
    assign host.rx_data    = rx_data_q;
    assign host.rx_valid   = rx_valid_q;
    assign host.tx_req     = tx_req_q;
    assign host.addr_match = addr_match_q;
    assign host.rw         = rw_q;
    assign host.busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master with hand-computed expectations.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_if u_if ();

    i2c_slave #(.SLAVE_ADDR(7'h55), .SYNC_STAGES(2)) dut (
        .clock (clock),
        .reset (reset),
        .scl   (scl),
        .sda   (sda),
        .host  (u_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int rx_valid_cnt = 0, tx_req_cnt = 0, addr_match_cnt = 0, dut_low_cnt = 0, long_cnt = 0;
    logic rx_valid_p = 1'b0, tx_req_p = 1'b0, addr_match_p = 1'b0;

    always @(negedge clock) begin
        if (u_if.rx_valid)   rx_valid_cnt++;
        if (u_if.tx_req)     tx_req_cnt++;
        if (u_if.addr_match) addr_match_cnt++;
        if (sda == 1'b0 && !m_sda_low) dut_low_cnt++;
        if ((u_if.rx_valid && rx_valid_p) || (u_if.tx_req && tx_req_p) ||
            (u_if.addr_match && addr_match_p)) long_cnt++;
        rx_valid_p   = u_if.rx_valid;
        tx_req_p     = u_if.tx_req;
        addr_match_p = u_if.addr_match;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; wait_clk(Q);
        scl = 1'b1;       wait_clk(Q);
        m_sda_low = 1'b1; wait_clk(Q);
        scl = 1'b0;       wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_clk(Q);
        scl = 1'b1;       wait_clk(Q);
        m_sda_low = 1'b0; wait_clk(4 * Q);
    endtask

    task automatic xfer_bit(input logic b, output logic rd);
        m_sda_low = ~b; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        rd = sda;       wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    // Master drives d (1 = release) for 8 bits, then 'ninth' on the ACK bit.
    task automatic xfer_byte(input logic [7:0] d, input logic ninth,
                             output logic [7:0] rd, output logic ninth_rd);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(d[i], b);
            rd[i] = b;
        end
        xfer_bit(ninth, ninth_rd);
    endtask

    logic [7:0] rd;
    logic       ack, b;
    int         s_rx, s_tx, s_am, s_low;

    task automatic snap();
        s_rx = rx_valid_cnt; s_tx = tx_req_cnt; s_am = addr_match_cnt; s_low = dut_low_cnt;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        u_if.tx_data = 8'h00;
        wait_clk(5);
        chk("rst_rx_data", 32'(u_if.rx_data), 32'h00);
        chk("rst_rx_valid", 32'(u_if.rx_valid), 32'h0);
        chk("rst_tx_req", 32'(u_if.tx_req), 32'h0);
        chk("rst_addr_match", 32'(u_if.addr_match), 32'h0);
        chk("rst_rw", 32'(u_if.rw), 32'h0);
        chk("rst_busy", 32'(u_if.busy), 32'h0);
        chk("rst_sda", 32'(sda), 32'h1);
        reset = 1'b0;
        wait_clk(10);

        // Write 0xA5 to 0x55
        snap();
        bus_start();
        chk("wr_busy", 32'(u_if.busy), 32'h1);
        xfer_byte(8'hAA, 1'b1, rd, ack);
        chk("wr_addr_ack", 32'(ack), 32'h0);
        chk("wr_rw", 32'(u_if.rw), 32'h0);
        xfer_byte(8'hA5, 1'b1, rd, ack);
        chk("wr_data_ack", 32'(ack), 32'h0);
        chk("wr_rx_data", 32'(u_if.rx_data), 32'hA5);
        bus_stop();
        chk("wr_busy_after_stop", 32'(u_if.busy), 32'h0);
        chk("wr_rx_valid_cnt", 32'(rx_valid_cnt - s_rx), 32'd1);
        chk("wr_addr_match_cnt", 32'(addr_match_cnt - s_am), 32'd1);

        // Address mismatch 0x2A
        snap();
        bus_start();
        xfer_byte(8'h54, 1'b1, rd, ack);
        chk("mm_addr_nack", 32'(ack), 32'h1);
        xfer_byte(8'h12, 1'b1, rd, ack);
        chk("mm_data_nack", 32'(ack), 32'h1);
        bus_stop();
        chk("mm_dut_low", 32'(dut_low_cnt - s_low), 32'd0);
        chk("mm_addr_match_cnt", 32'(addr_match_cnt - s_am), 32'd0);
        chk("mm_rx_valid_cnt", 32'(rx_valid_cnt - s_rx), 32'd0);
        chk("mm_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Read 0x3C (ACK) then 0xC3 (NACK)
        snap();
        u_if.tx_data = 8'h3C;
        bus_start();
        xfer_byte(8'hAB, 1'b1, rd, ack);
        chk("rd_addr_ack", 32'(ack), 32'h0);
        chk("rd_rw", 32'(u_if.rw), 32'h1);
        u_if.tx_data = 8'hC3;
        xfer_byte(8'hFF, 1'b0, rd, ack);
        chk("rd_byte0", 32'(rd), 32'h3C);
        xfer_byte(8'hFF, 1'b1, rd, ack);
        chk("rd_byte1", 32'(rd), 32'hC3);
        chk("rd_nack_released", 32'(ack), 32'h1);
        wait_clk(2);
        chk("rd_sda_released", 32'(sda), 32'h1);
        bus_stop();
        chk("rd_tx_req_cnt", 32'(tx_req_cnt - s_tx), 32'd2);
        chk("rd_busy_after_stop", 32'(u_if.busy), 32'h0);

        // Repeated START after 4 data bits
        snap();
        bus_start();
        xfer_byte(8'hAA, 1'b1, rd, ack);
        xfer_bit(1'b1, b); xfer_bit(1'b0, b); xfer_bit(1'b1, b); xfer_bit(1'b1, b);
        bus_start();
        xfer_byte(8'hAA, 1'b1, rd, ack);
        chk("rs_addr_ack", 32'(ack), 32'h0);
        xfer_byte(8'h0F, 1'b1, rd, ack);
        bus_stop();
        chk("rs_rx_data", 32'(u_if.rx_data), 32'h0F);
        chk("rs_rx_valid_cnt", 32'(rx_valid_cnt - s_rx), 32'd1);
        chk("rs_addr_match_cnt", 32'(addr_match_cnt - s_am), 32'd2);

        // STOP in the middle of a received byte
        snap();
        bus_start();
        xfer_byte(8'hAA, 1'b1, rd, ack);
        xfer_bit(1'b1, b); xfer_bit(1'b1, b); xfer_bit(1'b0, b);
        bus_stop();
        chk("sm_rx_valid_cnt", 32'(rx_valid_cnt - s_rx), 32'd0);
        chk("sm_rx_data", 32'(u_if.rx_data), 32'h0F);

        // Reset during the address ACK low phase
        bus_start();
        for (int i = 7; i >= 0; i--) xfer_bit(((8'hAA >> i) & 8'h01) != 8'h00, b);
        m_sda_low = 1'b0;
        wait_clk(2);
        chk("rs_ack_low", 32'(sda), 32'h0);
        reset = 1'b1;
        wait_clk(1);
        chk("rst_mid_sda", 32'(sda), 32'h1);
        chk("rst_mid_rx_data", 32'(u_if.rx_data), 32'h00);
        chk("rst_mid_busy", 32'(u_if.busy), 32'h0);
        chk("rst_mid_rw", 32'(u_if.rw), 32'h0);
        chk("rst_mid_addr_match", 32'(u_if.addr_match), 32'h0);
        scl = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(10);
        snap();
        bus_start();
        xfer_byte(8'hAA, 1'b1, rd, ack);
        chk("post_rst_addr_ack", 32'(ack), 32'h0);
        xfer_byte(8'h77, 1'b1, rd, ack);
        chk("post_rst_data_ack", 32'(ack), 32'h0);
        bus_stop();
        chk("post_rst_rx_data", 32'(u_if.rx_data), 32'h77);
        chk("post_rst_rx_valid_cnt", 32'(rx_valid_cnt - s_rx), 32'd1);

`ifdef I2C_GLITCH_FILTER_EN
        // Single-clock sda low pulse with scl high must not look like START
        wait_clk(5);
        m_sda_low = 1'b1;
        wait_clk(1);
        m_sda_low = 1'b0;
        wait_clk(20);
        chk("glitch_busy", 32'(u_if.busy), 32'h0);
        chk("glitch_state", 32'(dut.state_q), 32'(IDLE));
`endif

        chk("pulse_width", 32'(long_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
